bcd7_scan_driver: RTL and testbench

//  Sits downstream of the data-memory peripheral register at 0x4000_0010 (12-bit BCD7 word).

---
 rtl/bcd7_scan_driver.sv | 108 ++++++++++
 tb/tb_bcd7_scan_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bcd7_scan_driver.sv
// Per-digit segment store fed by the BCD7 register, with an autonomous blank/show scan of a 4-digit display.
// Pins are registered (1-cycle latency); no backpressure; raw passthrough mode bypasses the scan for pins only.
module bcd7_scan_driver #(
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] bcd7_in,
    input  logic        mode_passthru,
    input  logic        clear,
    output logic [3:0]  an_out,
    output logic [7:0]  seg_out,
    output logic [1:0]  scan_idx,
    output logic        frame_tick
);

    localparam int SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;
    localparam int CW          = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [3:0][7:0] digit;
    logic [3:0]      an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            tick_q, tick_d;

    // Clear wins over capture; capture keeps running in passthrough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bcd7_in[8+k]) digit[k] <= bcd7_in[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_BLANK;
            cnt    <= '0;
            idx    <= '0;
            an_q   <= '0;
            seg_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            an_q   <= an_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        tick_d    = 1'b0;
        an_d      = '0;
        seg_d     = '0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                    tick_d    = (idx == 2'd3);
                end
            end
            default: begin
                state_nxt = ST_BLANK;
                cnt_nxt   = '0;
            end
        endcase
        // Pin values are computed for the state being entered so they change on that edge.
        if (mode_passthru) begin
            an_d  = bcd7_in[11:8];
            seg_d = bcd7_in[7:0];
        end else if (state_nxt == ST_SHOW) begin
            an_d  = 4'b0001 << idx_nxt;
            seg_d = digit[idx_nxt];
        end
    end

    assign an_out     = an_q ^ {4{AN_ACTIVE_LOW}};
    assign seg_out    = seg_q ^ {8{SEG_ACTIVE_LOW}};
    assign scan_idx   = idx;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd7_scan_driver.sv
// Directed bench for bcd7_scan_driver with an 8-cycle slot (2 blank + 6 show), active-low anodes.
module tb_bcd7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] bcd7_in = '0;
    logic        mode_passthru = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  an_out;
    logic [7:0]  seg_out;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int ecnt;

    bcd7_scan_driver #(
        .SCAN_DIV(8), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .bcd7_in(bcd7_in), .mode_passthru(mode_passthru),
        .clear(clear), .an_out(an_out), .seg_out(seg_out), .scan_idx(scan_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge 1 is the first rising edge with reset high.
    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int e);
        int guard = 0;
        while (ecnt < e && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt < e) begin
            errors++;
            $display("FAIL go_to observed=%0d expected=%0d", ecnt, e);
        end
    endtask

    task automatic pins(input string tag, input logic [3:0] an, input logic [7:0] seg);
        chk({tag, "_an"}, {8'h0, an_out}, {8'h0, an});
        chk({tag, "_seg"}, {4'h0, seg_out}, {4'h0, seg});
    endtask

    initial begin
        // 1: reset values without any clock edge, then across edges
        #2;
        pins("rst_async", 4'hF, 8'h00);
        chk("rst_tick", {11'h0, frame_tick}, 12'h0);
        chk("rst_idx", {10'h0, scan_idx}, 12'h0);
        repeat (3) @(posedge clk);
        #1;
        pins("rst_held", 4'hF, 8'h00);
        reset = 1'b1;
        go_to(1);
        pins("first_blank", 4'hF, 8'h00);
        go_to(2);
        pins("first_show", 4'hE, 8'h00);
        chk("first_idx", {10'h0, scan_idx}, 12'h0);

        // 2: one write per digit
        bcd7_in = 12'h13F; go_to(3);
        bcd7_in = 12'h206; go_to(4);
        bcd7_in = 12'h45B; go_to(5);
        bcd7_in = 12'h84F; go_to(6);
        bcd7_in = 12'h000;
        go_to(7);
        pins("d0_show", 4'hE, 8'h3F);
        go_to(8);
        pins("d1_blank", 4'hF, 8'h00);
        chk("d1_idx", {10'h0, scan_idx}, 12'h1);
        go_to(12);
        pins("d1_show", 4'hD, 8'h06);
        go_to(17);
        pins("d2_blank", 4'hF, 8'h00);
        go_to(20);
        pins("d2_show", 4'hB, 8'h5B);
        go_to(28);
        pins("d3_show", 4'h7, 8'h4F);
        go_to(31);
        chk("tick_pre", {11'h0, frame_tick}, 12'h0);
        go_to(32);
        chk("tick_f0", {11'h0, frame_tick}, 12'h1);
        chk("tick_idx", {10'h0, scan_idx}, 12'h0);
        go_to(33);
        chk("tick_post", {11'h0, frame_tick}, 12'h0);

        // 3: broadcast write, then anode field zero writes nothing
        bcd7_in = 12'hF71; go_to(34);
        bcd7_in = 12'h071; go_to(35);
        bcd7_in = 12'h03F; go_to(36);
        bcd7_in = 12'h000;
        pins("bc_d0", 4'hE, 8'h71);
        go_to(44);
        pins("bc_d1", 4'hD, 8'h71);
        go_to(52);
        pins("bc_d2", 4'hB, 8'h71);
        go_to(60);
        pins("bc_d3", 4'h7, 8'h71);
        go_to(64);
        chk("tick_f1", {11'h0, frame_tick}, 12'h1);

        // 4: clear beats a same-cycle write
        clear = 1'b1; bcd7_in = 12'h1FF; go_to(65);
        clear = 1'b0; bcd7_in = 12'h000;
        go_to(68);
        pins("clr_d0", 4'hE, 8'h00);
        go_to(76);
        pins("clr_d1", 4'hD, 8'h00);

        // 5: passthrough for one cycle, then back to the scan
        mode_passthru = 1'b1; bcd7_in = 12'h479; go_to(77);
        mode_passthru = 1'b0; bcd7_in = 12'h000;
        pins("pt", 4'hB, 8'h79);
        chk("pt_idx", {10'h0, scan_idx}, 12'h1);
        go_to(78);
        pins("pt_exit", 4'hD, 8'h00);
        go_to(84);
        pins("pt_capt_d2", 4'hB, 8'h79);
        go_to(95);
        chk("tick_f2_pre", {11'h0, frame_tick}, 12'h0);
        go_to(96);
        chk("tick_f2", {11'h0, frame_tick}, 12'h1);

        // 6: reset mid-show of digit 2
        go_to(115);
        chk("pre_rst_idx", {10'h0, scan_idx}, 12'h2);
        pins("pre_rst", 4'hB, 8'h79);
        reset = 1'b0;
        #1;
        pins("mid_rst", 4'hF, 8'h00);
        chk("mid_rst_idx", {10'h0, scan_idx}, 12'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        go_to(1);
        pins("rel_blank", 4'hF, 8'h00);
        go_to(2);
        pins("rel_show", 4'hE, 8'h00);
        go_to(18);
        pins("rel_d2", 4'hB, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
